// File: rtl/unified_mem_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and load/store; data wins by default.
// Latency: grant/stall combinational in the request cycle, read data returns one cycle after the grant.
// Backpressure: losing requester sees its stall; optional starvation guard is UNIFIED_MEM_ARBITER_STARVE_GUARD_EN.
module unified_mem_arbiter #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDR_SIZE    = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic [DATA_SIZE-1:0] if_rdata,
    output logic                 if_rvalid,
    output logic                 if_stall,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [DATA_SIZE-1:0] d_wdata,
    output logic [DATA_SIZE-1:0] d_rdata,
    output logic                 d_rvalid,
    output logic                 d_stall,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic [1:0]           grant_owner
);

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_IF   = 2'd1;
    localparam logic [1:0] RSP_D    = 2'd2;

    logic [1:0] rsp_state;
    logic [1:0] rsp_next;

    // Requests are masked while reset is held so every output sits at its reset value.
    logic if_act;
    logic data_req;
    logic fetch_grant;
    logic data_grant;
    logic data_wr_grant;
    logic data_rd_grant;

    assign if_act   = RESET_N & if_req;
    assign data_req = RESET_N & (d_read | d_write);

`ifdef UNIFIED_MEM_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    assign starve_hit  = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign fetch_grant = if_act & (~data_req | starve_hit);

    // Count consecutive cycles fetch lost to data; any fetch grant or idle fetch clears it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_cnt <= '0;
        end else if (fetch_grant || !if_act) begin
            starve_cnt <= '0;
        end else if (data_grant && !starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign d_stall = data_req & ~data_grant;
`else
    // Strict data priority: the limit has no effect in this build.
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);

    assign fetch_grant = if_act & ~data_req;
    assign d_stall     = 1'b0;
`endif

    assign data_grant    = data_req & ~fetch_grant;
    assign data_wr_grant = data_grant & d_write;
    assign data_rd_grant = data_grant & ~d_write;

    assign if_stall    = if_act & ~fetch_grant;
    assign grant_owner = {data_grant, fetch_grant};

    // Steer the shared port to the granted requester; a store shadows a simultaneous load.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (fetch_grant) begin
            mem_addr = if_addr;
            mem_re   = 1'b1;
        end else if (data_wr_grant) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = 1'b1;
        end else if (data_rd_grant) begin
            mem_addr = d_addr;
            mem_re   = 1'b1;
        end
    end

    // Remember who owns the read data arriving next cycle; writes and idle give no response.
    always_comb begin
        rsp_next = RSP_NONE;
        if (fetch_grant) begin
            rsp_next = RSP_IF;
        end else if (data_rd_grant) begin
            rsp_next = RSP_D;
        end
    end

    // Response owner register; reset drops any in-flight response.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rsp_state <= RSP_NONE;
        end else begin
            rsp_state <= rsp_next;
        end
    end

    assign if_rvalid = (rsp_state == RSP_IF);
    assign d_rvalid  = (rsp_state == RSP_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: registered memory model, per-cycle grant model, read-response scoreboard.
// Latency: responses are expected exactly one cycle after the granted read.
// Backpressure: stall outputs compared every cycle against the bench's own arbitration model.
module tb_unified_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int LIMIT = 4;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_rvalid;
    logic          if_stall;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;
    logic          d_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    grant_owner;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          who;   // 0 none, 1 fetch, 2 data
        logic [31:0] dat;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [31:0] exp_mem[DEPTH];
    int          starve_cnt = 0;
    int          fetch_wins = 0;

    unified_mem_arbiter #(
        .DATA_SIZE   (DW),
        .ADDR_SIZE   (AW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_rvalid  (if_rvalid),
        .if_stall   (if_stall),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_rvalid   (d_rvalid),
        .d_stall    (d_stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .grant_owner(grant_owner)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int a);
        if (a == 5) return 32'h0050_0093;
        return 32'hC0DE_0000 ^ (a * 32'h0001_0101);
    endfunction

    // Registered single-port RAM model, preloaded on the first clock edge.
    logic [31:0] ram[DEPTH];
    bit          ram_loaded;
    always @(posedge CLK) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " if_rvalid"}, if_rvalid, 0);
        check({tag, " d_rvalid"}, d_rvalid, 0);
        check({tag, " if_rdata"}, if_rdata, 0);
        check({tag, " d_rdata"}, d_rdata, 0);
        check({tag, " grant_owner"}, grant_owner, 0);
        check({tag, " mem_re"}, mem_re, 0);
        check({tag, " mem_we"}, mem_we, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " if_stall"}, if_stall, 0);
        check({tag, " d_stall"}, d_stall, 0);
    endtask

    // One cycle: drive requests just after the rising edge, check at the falling edge, return after the next rise.
    task automatic step(input logic fr, input logic [AW-1:0] fa, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [31:0] dwd);
        logic        dreq, fg, dg, force_f;
        logic [31:0] e_addr;
        rsp_t        r;
        if_req  = fr;
        if_addr = fa;
        d_read  = dr;
        d_write = dw;
        d_addr  = da;
        d_wdata = dwd;
        @(negedge CLK);
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            check("if_rvalid", if_rvalid, (r.who == 1) ? 1 : 0);
            check("d_rvalid", d_rvalid, (r.who == 2) ? 1 : 0);
            check("if_rdata", if_rdata, (r.who == 1) ? r.dat : 32'h0);
            check("d_rdata", d_rdata, (r.who == 2) ? r.dat : 32'h0);
        end
        dreq = dr | dw;
`ifdef UNIFIED_MEM_ARBITER_STARVE_GUARD_EN
        force_f = fr & dreq & (starve_cnt == LIMIT);
`else
        force_f = 1'b0;
`endif
        fg = fr & (~dreq | force_f);
        dg = dreq & ~fg;
        e_addr = fg ? 32'(fa) : (dg ? 32'(da) : 32'h0);
        check("grant_owner", grant_owner, {dg, fg});
        check("if_stall", if_stall, fr & ~fg);
`ifdef UNIFIED_MEM_ARBITER_STARVE_GUARD_EN
        check("d_stall", d_stall, dreq & ~dg);
`else
        check("d_stall", d_stall, 0);
`endif
        check("mem_re", mem_re, fg | (dg & ~dw));
        check("mem_we", mem_we, dg & dw);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, (dg & dw) ? dwd : 32'h0);
        r.who = fg ? 1 : ((dg & ~dw) ? 2 : 0);
        r.dat = fg ? exp_mem[fa] : exp_mem[da];
        rsp_q.push_back(r);
        if (dg & dw) exp_mem[da] = dwd;
        if (fg) fetch_wins++;
        if (fg || !fr) starve_cnt = 0;
        else if (dg && starve_cnt < LIMIT) starve_cnt++;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
        // Reset held with every request asserted: outputs must stay quiet.
        RESET_N = 1'b0;
        if_req  = 1'b1;
        if_addr = 10'h123;
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 10'h0AA;
        d_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        if_req  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Reset mid-read: the fetch response must be dropped.
        step(1, 10'h010, 0, 0, 0, 0);
        RESET_N = 1'b0;
        #1;
        check("rst_mid if_rvalid", if_rvalid, 0);
        rsp_q.delete();
        starve_cnt = 0;
        @(negedge CLK);
        check_reset_outputs("rst_mid");
        if_req  = 1'b0;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Fetch only.
        step(1, 10'h005, 0, 0, 0, 0);
        idle();

        // Collision: data wins, then fetch once the load drops.
        step(1, 10'h006, 1, 0, 10'h100, 0);
        step(1, 10'h006, 0, 0, 0, 0);
        idle();

        // Store at the top address and read it back; address 0 fetch.
        step(0, 0, 0, 1, 10'h3FF, 32'hDEAD_BEEF);
        step(0, 0, 1, 0, 10'h3FF, 0);
        step(1, 10'h000, 0, 0, 0, 0);
        step(0, 0, 1, 0, 10'h000, 0);
        idle();

        // Read and write together: only the write happens.
        step(0, 0, 1, 1, 10'h020, 32'h1234_5678);
        step(0, 0, 1, 0, 10'h020, 0);
        idle();

        // Contested stream: starvation behaviour depends on the build.
        fetch_wins = 0;
        for (int i = 0; i < 12; i++) step(1, 10'(i), 1, 0, 10'(10'h200 + i), 0);
`ifdef UNIFIED_MEM_ARBITER_STARVE_GUARD_EN
        check("starve fetch wins", fetch_wins, 2);
`else
        check("starve fetch wins", fetch_wins, 0);
`endif
        idle();

        // Back-to-back alternating requesters.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 10'(10'h040 + i), 0, 0, 0, 0);
            else            step(0, 0, 1, 0, 10'(10'h080 + i), 0);
        end
        idle();

        // Random traffic, addresses concentrated in a small window to hit stores and readbacks.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 10'($urandom_range(0, 31)), $urandom);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
